// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by datapath packages.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/dp_types_pkg.sv
// BTB entry and 2-bit predictor counter types, plus the saturating counter step.
package dp_types_pkg;
  import cpu_types_pkg::*;

  // Wide enough for the smallest table (2 entries); larger tables zero-fill the top tag bits.
  localparam int TAG_W = 30;
  typedef logic [TAG_W-1:0] btb_tag_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bpcnt_t;

  typedef struct packed {
    logic     valid;
    btb_tag_t tag;
    word_t    target;
    bpcnt_t   cnt;
  } btb_entry_t;

  function automatic bpcnt_t bpcnt_step(input bpcnt_t c, input logic taken);
    bpcnt_t n;
    n = c;
    case (c)
      STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  n = taken ? STRONG_T : WEAK_T;
      default:   n = WEAK_NT;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, update commits on the edge after upd_valid & upd_en.
// No backpressure of its own; upd_en low (pipeline stall) freezes the table and mispredict count.
module branch_predictor
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  word_t       if_pc,
  output logic        pred_taken,
  output word_t       pred_target,
  input  logic        upd_valid,
  input  logic        upd_en,
  input  word_t       upd_pc,
  input  logic        upd_taken,
  input  word_t       upd_target,
  input  logic        upd_pred_taken,
  input  word_t       upd_pred_target,
  output logic        phit,
  output logic [15:0] mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] if_idx, upd_idx;
  btb_tag_t         if_tag, upd_tag;
  btb_entry_t       if_ent, upd_ent;
  logic             upd_hit;

  // PC bits [1:0] are dropped by the shifts, so unaligned PCs alias to their word.
  always_comb begin
    if_idx  = IDX_W'(if_pc >> 2);
    if_tag  = TAG_W'(if_pc >> (IDX_W + 2));
    upd_idx = IDX_W'(upd_pc >> 2);
    upd_tag = TAG_W'(upd_pc >> (IDX_W + 2));
    if_ent  = btb_q[if_idx];
    upd_ent = btb_q[upd_idx];
    upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    pred_taken  = if_ent.valid && (if_ent.tag == if_tag) && if_ent.cnt[1];
    pred_target = pred_taken ? if_ent.target : (if_pc + 32'd4);

    phit = 1'b1;
    if (upd_valid) begin
      if (upd_pred_taken != upd_taken)
        phit = 1'b0;
      else if (upd_taken && (upd_pred_target != upd_target))
        phit = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};
      end
      mispredicts <= '0;
    end else if (upd_valid && upd_en) begin
      if (upd_hit) begin
        btb_q[upd_idx].cnt <= bpcnt_step(upd_ent.cnt, upd_taken);
        if (upd_taken)
          btb_q[upd_idx].target <= upd_target;
      end else if (upd_taken) begin
        btb_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, cnt: WEAK_T};
      end
      if (!phit && (mispredicts != 16'hFFFF))
        mispredicts <= mispredicts + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: vector table for combinational paths, hand sequences for training/reset.
module tb_branch_predictor;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  word_t       if_pc = 32'h40;
  logic        pred_taken;
  word_t       pred_target;
  logic        upd_valid = 1'b0;
  logic        upd_en = 1'b0;
  word_t       upd_pc = '0;
  logic        upd_taken = 1'b0;
  word_t       upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  word_t       upd_pred_target = '0;
  logic        phit;
  logic [15:0] mispredicts;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor #(.ENTRIES(8)) dut (
    .CLK(CLK), .nRST(nRST), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .phit(phit), .mispredicts(mispredicts)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic look(input string name, input word_t pc, input logic exp_t, input word_t exp_tgt);
    if_pc = pc;
    #1;
    chk({name, ".taken"}, 32'(pred_taken), 32'(exp_t));
    chk({name, ".target"}, pred_target, exp_tgt);
  endtask

  task automatic set_upd(input word_t pc, input logic t, input word_t tgt, input logic pt, input word_t ptgt);
    upd_pc = pc; upd_taken = t; upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
  endtask

  task automatic commit(input string name, input word_t pc, input logic t, input word_t tgt,
                        input logic pt, input word_t ptgt, input logic exp_phit, input int exp_mis);
    @(negedge CLK);
    set_upd(pc, t, tgt, pt, ptgt);
    upd_valid = 1'b1; upd_en = 1'b1;
    #1;
    chk({name, ".phit"}, 32'(phit), 32'(exp_phit));
    @(posedge CLK);
    #1;
    upd_valid = 1'b0; upd_en = 1'b0;
    chk({name, ".mispredicts"}, 32'(mispredicts), exp_mis);
  endtask

  typedef struct {
    logic  v, pt, t;
    word_t ptgt, tgt;
    word_t pc;
    logic  exp_phit;
    word_t exp_tgt;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{v:0, pt:1, t:0, ptgt:32'h0,   tgt:32'h0,   pc:32'h40,       exp_phit:1, exp_tgt:32'h44};
    vt[1] = '{v:1, pt:0, t:0, ptgt:32'h0,   tgt:32'h0,   pc:32'h13,       exp_phit:1, exp_tgt:32'h17};
    vt[2] = '{v:1, pt:1, t:1, ptgt:32'h100, tgt:32'h100, pc:32'hFFFFFFFC, exp_phit:1, exp_tgt:32'h0};
    vt[3] = '{v:1, pt:1, t:1, ptgt:32'h100, tgt:32'h104, pc:32'h80,       exp_phit:0, exp_tgt:32'h84};
    vt[4] = '{v:1, pt:0, t:1, ptgt:32'h0,   tgt:32'h100, pc:32'h42,       exp_phit:0, exp_tgt:32'h46};
    vt[5] = '{v:1, pt:1, t:0, ptgt:32'h100, tgt:32'h0,   pc:32'h1000,     exp_phit:0, exp_tgt:32'h1004};
    vt[6] = '{v:1, pt:0, t:0, ptgt:32'h200, tgt:32'h300, pc:32'h7C,       exp_phit:1, exp_tgt:32'h80};
    vt[7] = '{v:0, pt:0, t:1, ptgt:32'h0,   tgt:32'h500, pc:32'h60,       exp_phit:1, exp_tgt:32'h64};

    // Reset state, observed while reset is still asserted.
    #3;
    look("rst_lookup", 32'h40, 1'b0, 32'h44);
    chk("rst_phit", 32'(phit), 32'd1);
    chk("rst_mis", 32'(mispredicts), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Combinational phit and lookup on an empty table; upd_en low so nothing commits.
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      set_upd(32'h40, vt[i].t, vt[i].tgt, vt[i].pt, vt[i].ptgt);
      upd_valid = vt[i].v;
      upd_en = 1'b0;
      look($sformatf("vec%0d", i), vt[i].pc, 1'b0, vt[i].exp_tgt);
      chk($sformatf("vec%0d.phit", i), 32'(phit), 32'(vt[i].exp_phit));
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d.mis", i), 32'(mispredicts), 32'd0);
    end
    upd_valid = 1'b0;

    // First taken commit allocates; same-cycle lookup still sees the old table.
    @(negedge CLK);
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    upd_valid = 1'b1; upd_en = 1'b1;
    look("alloc_same_cycle", 32'h40, 1'b0, 32'h44);
    chk("alloc.phit", 32'(phit), 32'd0);
    @(posedge CLK);
    #1;
    upd_valid = 1'b0; upd_en = 1'b0;
    look("alloc_next", 32'h40, 1'b1, 32'h100);
    look("alloc_unaligned", 32'h42, 1'b1, 32'h100);
    chk("alloc.mis", 32'(mispredicts), 32'd1);

    // Counter walk: WEAK_T -> WEAK_NT -> STRONG_NT -> ... -> STRONG_T (saturate) -> WEAK_T.
    commit("nt1", 32'h40, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 2);
    look("nt1", 32'h40, 1'b0, 32'h44);
    commit("nt2", 32'h40, 1'b0, 32'h0,   1'b0, 32'h44,  1'b1, 2);
    look("nt2", 32'h40, 1'b0, 32'h44);
    commit("t1",  32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b0, 3);
    look("t1", 32'h40, 1'b0, 32'h44);
    commit("t2",  32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b0, 4);
    look("t2", 32'h40, 1'b1, 32'h100);
    commit("t3",  32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 4);
    commit("t4",  32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 4);
    commit("nt3", 32'h40, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 5);
    look("sat_hold", 32'h40, 1'b1, 32'h100);
    commit("retarget", 32'h40, 1'b1, 32'h180, 1'b1, 32'h100, 1'b0, 6);
    look("retarget", 32'h40, 1'b1, 32'h180);

    // Aliasing: 0x60 shares index 0 with 0x40.
    commit("alias", 32'h60, 1'b1, 32'h200, 1'b0, 32'h64, 1'b0, 7);
    look("alias_old", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'h60, 1'b1, 32'h200);
    commit("alias_nt", 32'h60, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 8);
    look("alias_weak", 32'h60, 1'b0, 32'h64);
    commit("miss_nt", 32'h44, 1'b0, 32'h0, 1'b0, 32'h48, 1'b1, 8);
    look("miss_nt", 32'h44, 1'b0, 32'h48);

    // Stall: taken mismatch held with upd_en low for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      set_upd(32'h48, 1'b1, 32'h300, 1'b0, 32'h4C);
      upd_valid = 1'b1; upd_en = 1'b0;
      #1;
      chk($sformatf("stall%0d.phit", i), 32'(phit), 32'd0);
    end
    @(posedge CLK);
    #1;
    upd_valid = 1'b0;
    look("stall", 32'h48, 1'b0, 32'h4C);
    chk("stall.mis", 32'(mispredicts), 32'd8);

    // Train four entries, then reset asynchronously between edges.
    for (int i = 0; i < 4; i++)
      commit($sformatf("train%0d", i), 32'h100 + 32'(4 * i), 1'b1, 32'h500 + 32'(4 * i),
             1'b0, 32'h104 + 32'(4 * i), 1'b0, 9 + i);
    look("trained", 32'h104, 1'b1, 32'h504);
    @(posedge CLK);
    #3;
    nRST = 1'b0;
    for (int i = 0; i < 4; i++)
      look($sformatf("arst%0d", i), 32'h100 + 32'(4 * i), 1'b0, 32'h104 + 32'(4 * i));
    chk("arst.mis", 32'(mispredicts), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Reset landing on a pending update discards it.
    @(negedge CLK);
    set_upd(32'h120, 1'b1, 32'h700, 1'b0, 32'h124);
    upd_valid = 1'b1; upd_en = 1'b1;
    #2;
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    upd_valid = 1'b0; upd_en = 1'b0;
    nRST = 1'b1;
    look("rst_mid_upd", 32'h120, 1'b0, 32'h124);
    chk("rst_mid_upd.mis", 32'(mispredicts), 32'd0);

    // Mispredict counter saturation.
    @(negedge CLK);
    set_upd(32'h200, 1'b1, 32'h10, 1'b0, 32'h204);
    upd_valid = 1'b1; upd_en = 1'b1;
    repeat (65534) @(posedge CLK);
    #1;
    chk("sat_fffe", 32'(mispredicts), 32'hFFFE);
    repeat (3) @(posedge CLK);
    #1;
    chk("sat_ffff", 32'(mispredicts), 32'hFFFF);
    upd_valid = 1'b0; upd_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
